// File: rtl/mem_sequencer.sv
// Memory-bus sequencer for the single-cycle datapath: fetch, optional load/store,
// then a one-cycle mem_done pulse; faults are sticky until reset.
module mem_sequencer #(
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] pc_addr,
    input  logic [31:0] data_addr,
    input  logic [31:0] store_data,
    input  logic        load_req,
    input  logic        store_req,
    output logic [31:0] instr,
    output logic [31:0] load_data,
    output logic        mem_done,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StData,
        StDone,
        StFault
    } state_e;

    localparam logic [1:0] CauseTimeout = 2'b01;
    localparam logic [1:0] CauseFetch   = 2'b10;
    localparam logic [1:0] CauseData    = 2'b11;

    state_e      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic [31:0] instr_q, instr_d;
    logic        mem_done_q, mem_done_d;
    logic        fault_q, fault_d;
    logic [1:0]  fault_cause_q, fault_cause_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] tmo_q, tmo_d;
    logic        timed_out;

    // Last allowed wait cycle; an ack in this same cycle still wins.
    assign timed_out = (TIMEOUT != 0) && (tmo_q == TIMEOUT - 1);

    always_comb begin
        state_d       = state_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        load_data_d   = load_data_q;
        instr_d       = instr_q;
        mem_done_d    = 1'b0;
        fault_d       = fault_q;
        fault_cause_d = fault_cause_q;
        instret_d     = instret_q;
        tmo_d         = tmo_q;

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    if (pc_addr[1:0] == 2'b00) begin
                        state_d    = StFetch;
                        bus_req_d  = 1'b1;
                        bus_we_d   = 1'b0;
                        bus_addr_d = pc_addr;
                        tmo_d      = '0;
                    end else begin
                        state_d       = StFault;
                        fault_d       = 1'b1;
                        fault_cause_d = CauseFetch;
                    end
                end
            end
            StFetch: begin
                if (bus_ack) begin
                    instr_d   = bus_rdata;
                    bus_req_d = 1'b0;
                    state_d   = StDecode;
                end else if (timed_out) begin
                    state_d       = StFault;
                    bus_req_d     = 1'b0;
                    bus_we_d      = 1'b0;
                    fault_d       = 1'b1;
                    fault_cause_d = CauseTimeout;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            StDecode: begin
                if (load_req || store_req) begin
                    if (data_addr[1:0] != 2'b00) begin
                        state_d       = StFault;
                        fault_d       = 1'b1;
                        fault_cause_d = CauseData;
                    end else begin
                        // Store wins when both requests are raised.
                        state_d    = StData;
                        bus_req_d  = 1'b1;
                        bus_we_d   = store_req;
                        bus_addr_d = data_addr;
                        tmo_d      = '0;
                        if (store_req) begin
                            bus_wdata_d = store_data;
                        end
                    end
                end else begin
                    state_d    = StDone;
                    mem_done_d = 1'b1;
                end
            end
            StData: begin
                if (bus_ack) begin
                    if (!bus_we_q) begin
                        load_data_d = bus_rdata;
                    end
                    bus_req_d  = 1'b0;
                    bus_we_d   = 1'b0;
                    state_d    = StDone;
                    mem_done_d = 1'b1;
                end else if (timed_out) begin
                    state_d       = StFault;
                    bus_req_d     = 1'b0;
                    bus_we_d      = 1'b0;
                    fault_d       = 1'b1;
                    fault_cause_d = CauseTimeout;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            StDone: begin
                instret_d = instret_q + 32'd1;
                if (!run) begin
                    state_d = StIdle;
                end else if (pc_addr[1:0] == 2'b00) begin
                    state_d    = StFetch;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_addr_d = pc_addr;
                    tmo_d      = '0;
                end else begin
                    state_d       = StFault;
                    fault_d       = 1'b1;
                    fault_cause_d = CauseFetch;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            load_data_q   <= '0;
            instr_q       <= '0;
            mem_done_q    <= 1'b0;
            fault_q       <= 1'b0;
            fault_cause_q <= 2'b00;
            instret_q     <= '0;
            tmo_q         <= '0;
        end else begin
            state_q       <= state_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            load_data_q   <= load_data_d;
            instr_q       <= instr_d;
            mem_done_q    <= mem_done_d;
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
            instret_q     <= instret_d;
            tmo_q         <= tmo_d;
        end
    end

    // The datapath only ever sees a fetched instruction while it is current.
    assign instr = (state_q == StDecode || state_q == StData || state_q == StDone) ?
                   instr_q : NOP_INSTR;

    assign load_data   = load_data_q;
    assign mem_done    = mem_done_q;
    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign fault       = fault_q;
    assign fault_cause = fault_cause_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer: a per-instruction cycle-schedule model drives
// the bus and publishes the expected outputs, which a negedge process compares.
module tb_mem_sequencer;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] ADD2 = 32'h00A00113;
    localparam logic [31:0] LW   = 32'h10002183;
    localparam logic [31:0] SW   = 32'h20202023;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [31:0] pc_addr, data_addr, store_data;
    logic        load_req, store_req;
    logic [31:0] instr, load_data;
    logic        mem_done;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ack;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] instret;

    mem_sequencer #(
        .TIMEOUT  (4),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .pc_addr    (pc_addr),
        .data_addr  (data_addr),
        .store_data (store_data),
        .load_req   (load_req),
        .store_req  (store_req),
        .instr      (instr),
        .load_data  (load_data),
        .mem_done   (mem_done),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .fault      (fault),
        .fault_cause(fault_cause),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int done_cnt = 0;

    // Model state: architectural view, updated per instruction.
    logic [31:0] m_instret, m_load;
    logic        m_fault;
    logic [1:0]  m_cause;

    // Expected outputs for the current cycle.
    bit          exp_on = 1'b0;
    logic        e_req, e_we, e_done;
    logic [31:0] e_addr, e_wdata, e_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    endtask

    always @(negedge clk) begin
        if (exp_on) begin
            chk("bus_req", 32'(bus_req), 32'(e_req));
            chk("bus_we", 32'(bus_we), 32'(e_we));
            if (e_req) chk("bus_addr", bus_addr, e_addr);
            if (e_req && e_we) chk("bus_wdata", bus_wdata, e_wdata);
            chk("instr", instr, e_instr);
            chk("mem_done", 32'(mem_done), 32'(e_done));
            chk("load_data", load_data, m_load);
            chk("instret", instret, m_instret);
            chk("fault", 32'(fault), 32'(m_fault));
            chk("fault_cause", 32'(fault_cause), 32'(m_cause));
            if (mem_done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] ins, input logic done);
        e_req = req; e_we = we; e_addr = addr; e_wdata = wdata; e_instr = ins; e_done = done;
        exp_on = 1'b1;
    endtask

    task automatic model_reset();
        m_instret = '0; m_load = '0; m_fault = 1'b0; m_cause = 2'b00;
    endtask

    task automatic do_reset();
        exp_on = 1'b0; rst = 1'b1; run = 1'b0; bus_ack = 1'b0;
        load_req = 1'b0; store_req = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic idle(input logic r, input logic [31:0] pc);
        run = r; pc_addr = pc;
        set_exp(1'b0, 1'b0, 32'h0, 32'h0, NOP, 1'b0);
        tick();
    endtask

    task automatic fault_cyc(input int n);
        for (int i = 0; i < n; i++) begin
            bus_ack = (i == 1);  // stray ack while no request is outstanding
            set_exp(1'b0, 1'b0, 32'h0, 32'h0, NOP, 1'b0);
            tick();
        end
        bus_ack = 1'b0;
    endtask

    // One instruction: fw/dw are wait states before the ack of fetch/data.
    task automatic do_instr(input logic [31:0] pc, input logic [31:0] word, input int fw,
                            input bit ld, input bit st, input logic [31:0] da,
                            input logic [31:0] sd, input logic [31:0] rd, input int dw,
                            input logic [31:0] npc, input logic nrun);
        load_req = 1'b0; store_req = 1'b0;
        for (int i = 0; i <= fw; i++) begin
            bus_ack = (i == fw); bus_rdata = (i == fw) ? word : 32'hBADBAD00;
            set_exp(1'b1, 1'b0, pc, 32'h0, NOP, 1'b0);
            tick();
        end
        bus_ack = 1'b0; bus_rdata = 32'hBADBAD01;
        load_req = ld; store_req = st; data_addr = da; store_data = sd;
        set_exp(1'b0, 1'b0, 32'h0, 32'h0, word, 1'b0);
        tick();
        load_req = 1'b0; store_req = 1'b0;
        if (ld || st) begin
            if (da[1:0] != 2'b00) begin
                m_fault = 1'b1; m_cause = 2'b11;
                return;
            end
            for (int j = 0; j <= dw; j++) begin
                bus_ack = (j == dw); bus_rdata = (j == dw) ? rd : 32'hBADBAD02;
                set_exp(1'b1, st, da, sd, word, 1'b0);
                tick();
            end
            bus_ack = 1'b0;
            if (ld && !st) m_load = rd;
        end
        pc_addr = npc; run = nrun;
        set_exp(1'b0, 1'b0, 32'h0, 32'h0, word, 1'b1);
        tick();
        m_instret = m_instret + 32'd1;
        if (nrun && npc[1:0] != 2'b00) begin
            m_fault = 1'b1; m_cause = 2'b10;
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; pc_addr = '0; data_addr = '0; store_data = '0;
        load_req = 1'b0; store_req = 1'b0; bus_rdata = '0; bus_ack = 1'b0;
        model_reset();
        tick();
        tick();
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_instr_nop", instr, 32'h00000013);
        chk("rst_bus_req", 32'(bus_req), 32'h0);
        rst = 1'b0;

        // Mixed program: zero-wait ALU, load with 2 waits, store, fetch acked at
        // the last allowed cycle, and load+store where the store wins.
        idle(1'b0, 32'h0);
        idle(1'b1, 32'h0);
        do_instr(32'h0, ADDI, 0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 32'h4, 1'b1);
        do_instr(32'h4, LW, 0, 1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 32'h8, 1'b1);
        do_instr(32'h8, SW, 1, 1'b0, 1'b1, 32'h200, 32'h12345678, 32'h0, 0, 32'hC, 1'b1);
        do_instr(32'hC, ADD2, 3, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 32'h10, 1'b1);
        do_instr(32'h10, SW, 0, 1'b1, 1'b1, 32'h204, 32'hA5A5A5A5, 32'h11111111, 1,
                 32'h14, 1'b0);
        idle(1'b0, 32'h14);
        chk("prog_instret", instret, 32'd5);
        chk("prog_load_data", load_data, 32'hDEADBEEF);
        chk("prog_done_pulses", 32'(done_cnt), 32'd5);
        chk("prog_last_wdata", bus_wdata, 32'hA5A5A5A5);

        // Fetch never acked: exactly four request cycles, then a timeout fault.
        do_reset();
        idle(1'b1, 32'h20);
        for (int i = 0; i < 4; i++) begin
            set_exp(1'b1, 1'b0, 32'h20, 32'h0, NOP, 1'b0);
            tick();
        end
        m_fault = 1'b1; m_cause = 2'b01;
        fault_cyc(4);
        chk("tmo_cause", 32'(fault_cause), 32'h1);

        // Misaligned fetch straight from idle.
        do_reset();
        idle(1'b1, 32'h6);
        m_fault = 1'b1; m_cause = 2'b10;
        fault_cyc(3);
        chk("misfetch_cause", 32'(fault_cause), 32'h2);

        // Misaligned load address.
        do_reset();
        idle(1'b1, 32'h30);
        do_instr(32'h30, LW, 0, 1'b1, 1'b0, 32'h101, 32'h0, 32'h0, 0, 32'h34, 1'b1);
        fault_cyc(3);
        chk("misdata_cause", 32'(fault_cause), 32'h3);

        // Misaligned next PC presented in the completion cycle.
        do_reset();
        idle(1'b1, 32'h40);
        do_instr(32'h40, ADDI, 0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 32'h42, 1'b1);
        fault_cyc(2);
        chk("misnext_instret", instret, 32'd1);

        // Asynchronous reset in the middle of a load's data phase.
        do_reset();
        idle(1'b1, 32'h0);
        do_instr(32'h0, ADDI, 0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 32'h4, 1'b1);
        bus_ack = 1'b1; bus_rdata = LW;
        set_exp(1'b1, 1'b0, 32'h4, 32'h0, NOP, 1'b0);
        tick();
        bus_ack = 1'b0; load_req = 1'b1; data_addr = 32'h100;
        set_exp(1'b0, 1'b0, 32'h0, 32'h0, LW, 1'b0);
        tick();
        load_req = 1'b0;
        chk("pre_rst_req", 32'(bus_req), 32'h1);
        chk("pre_rst_instret", instret, 32'd1);
        exp_on = 1'b0;
        #2;
        rst = 1'b1; run = 1'b0;
        #1;
        chk("async_rst_req", 32'(bus_req), 32'h0);
        chk("async_rst_instret", instret, 32'h0);
        chk("async_rst_instr", instr, NOP);
        tick();
        rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        model_reset();
        idle(1'b0, 32'h8);
        bus_ack = 1'b0;
        idle(1'b0, 32'h8);
        chk("late_ack_load", load_data, 32'h0);
        idle(1'b1, 32'h8);
        do_instr(32'h8, ADD2, 0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 32'hC, 1'b0);
        idle(1'b0, 32'hC);
        chk("restart_instret", instret, 32'd1);
        exp_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
